// File: rtl/tcm_dpram_param_pkg.sv
// rtl/tcm_dpram_param_pkg.sv - shared constants and types for the parametrised dual-port TCM RAM
package tcm_dpram_param_pkg;

    // Same-port read+write behaviour selectors
    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Memory-clear sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/tcm_dpram_param_clr_fsm.sv
// rtl/tcm_dpram_param_clr_fsm.sv - memory-clear sequencer: walks every word and gates array access
module tcm_dpram_param_clr_fsm
    import tcm_dpram_param_pkg::*;
#(
    parameter int DEPTH          = 8192,
    parameter int AW             = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_i,
    output logic          ready_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          clr_we_o
);

    clr_state_t    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_ready;
    logic          r_clr_we;

    // Clear sequencer: one zero-write per cycle, ready rises the cycle after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_cnt <= '0;
            r_ready   <= !CLEAR_ON_RESET;
            r_clr_we  <= CLEAR_ON_RESET;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init_i) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_ready   <= 1'b0;
                        r_clr_we  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                        r_ready   <= 1'b1;
                        r_clr_we  <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ready  <= 1'b1;
                    r_clr_we <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign clr_addr_o = r_clr_cnt;
    assign clr_we_o   = r_clr_we;

endmodule

// File: rtl/tcm_dpram_param.sv
// rtl/tcm_dpram_param.sv - parametrised true dual-port TCM RAM with byte enables and clear sequencer
module tcm_dpram_param
    import tcm_dpram_param_pkg::*;
#(
    parameter int  DATA_W         = 64,
    parameter int  DEPTH          = 8192,
    parameter int  READ_LATENCY   = 1,
    parameter int  READ_MODE      = 0,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int NB             = DATA_W / 8,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    output logic              ready_o,
    input  logic [AW-1:0]     addr0_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [NB-1:0]     wr0_i,
    input  logic              rd0_i,
    output logic [DATA_W-1:0] data0_o,
    output logic              valid0_o,
    input  logic [AW-1:0]     addr1_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [NB-1:0]     wr1_i,
    input  logic              rd1_i,
    output logic [DATA_W-1:0] data1_o,
    output logic              valid1_o,
    output logic              collision_o
);

    logic                   w_ready;
    logic                   w_access;
    logic                   w_clr_we;
    logic [AW-1:0]          w_clr_addr;

    logic [1:0][AW-1:0]     w_addr;
    logic [1:0][DATA_W-1:0] w_din;
    logic [1:0][NB-1:0]     w_wr_req;
    logic [1:0]             w_rd;
    logic [1:0][DATA_W-1:0] w_dout;
    logic [1:0]             w_vout;

    logic [AW-1:0]          w_waddr0;
    logic [DATA_W-1:0]      w_wdata0;
    logic [NB-1:0]          w_be0;
    logic [NB-1:0]          w_be1;

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic                   r_collision;

    tcm_dpram_param_clr_fsm #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .init_i     (init_i),
        .ready_o    (w_ready),
        .clr_addr_o (w_clr_addr),
        .clr_we_o   (w_clr_we)
    );

    // Port traffic is only accepted while the array is ready and not being reset
    assign w_access    = w_ready & ~rst;
    assign w_addr[0]   = addr0_i;
    assign w_addr[1]   = addr1_i;
    assign w_din[0]    = data0_i;
    assign w_din[1]    = data1_i;
    assign w_wr_req[0] = w_access ? wr0_i : '0;
    assign w_wr_req[1] = w_access ? wr1_i : '0;
    assign w_rd[0]     = rd0_i & w_access;
    assign w_rd[1]     = rd1_i & w_access;

    // The clear sequencer borrows port 0's write path; port 0 wins any shared lane
    assign w_waddr0 = w_clr_we ? w_clr_addr : addr0_i;
    assign w_wdata0 = w_clr_we ? '0 : data0_i;
    assign w_be0    = (w_clr_we & ~rst) ? '1 : w_wr_req[0];
    assign w_be1    = (addr1_i == addr0_i) ? (w_wr_req[1] & ~w_wr_req[0]) : w_wr_req[1];

    // Array write: per-lane enables for both ports
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_be0[b]) r_mem[w_waddr0][b*8 +: 8] <= w_wdata0[b*8 +: 8];
            if (w_be1[b]) r_mem[addr1_i][b*8 +: 8]  <= data1_i[b*8 +: 8];
        end
    end

    // Collision flag: both ports enabled a common lane of the same word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= (addr0_i == addr1_i) && (|(w_wr_req[0] & w_wr_req[1]));
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] r_d1;
        logic              r_v1;

        // Read stage 1: array read sees pre-write data; write-first bypasses own enabled lanes
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v1 <= 1'b0;
                r_d1 <= '0;
            end else begin
                r_v1 <= w_rd[p];
                if (w_rd[p]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (READ_MODE == WRITE_FIRST && w_wr_req[p][b]) begin
                            r_d1[b*8 +: 8] <= w_din[p][b*8 +: 8];
                        end else begin
                            r_d1[b*8 +: 8] <= r_mem[w_addr[p]][b*8 +: 8];
                        end
                    end
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] r_d2;
            logic              r_v2;

            // Read stage 2: extra output register, data held between completed reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            end

            assign w_dout[p] = r_d2;
            assign w_vout[p] = r_v2;
        end else begin : g_lat1
            assign w_dout[p] = r_d1;
            assign w_vout[p] = r_v1;
        end
    end

    assign ready_o     = w_ready;
    assign data0_o     = w_dout[0];
    assign valid0_o    = w_vout[0];
    assign data1_o     = w_dout[1];
    assign valid1_o    = w_vout[1];
    assign collision_o = r_collision;

endmodule

// File: tb/tb_tcm_dpram_param.sv
// tb/tb_tcm_dpram_param.sv - self-checking bench for tcm_dpram_param (two configurations, shared stimulus)
module tb_tcm_dpram_param;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NB    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, init;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [NB-1:0] w0, w1;
    logic          r0, r1;

    logic          ready_a, ready_b, coll_a, coll_b;
    logic [DW-1:0] a_d0, a_d1, b_d0, b_d1;
    logic          a_v0, a_v1, b_v0, b_v1;

    // index k: 0 = A port0, 1 = A port1, 2 = B port0, 3 = B port1
    logic [DW-1:0] dout [4];
    logic          vout [4];

    always_comb begin
        dout[0] = a_d0; dout[1] = a_d1; dout[2] = b_d0; dout[3] = b_d1;
        vout[0] = a_v0; vout[1] = a_v1; vout[2] = b_v0; vout[3] = b_v1;
    end

    // A: 1-cycle latency, read-first
    tcm_dpram_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(1), .READ_MODE(0), .CLEAR_ON_RESET(1'b1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .init_i(init), .ready_o(ready_a),
        .addr0_i(a0), .data0_i(d0), .wr0_i(w0), .rd0_i(r0), .data0_o(a_d0), .valid0_o(a_v0),
        .addr1_i(a1), .data1_i(d1), .wr1_i(w1), .rd1_i(r1), .data1_o(a_d1), .valid1_o(a_v1),
        .collision_o(coll_a)
    );

    // B: 2-cycle latency, write-first
    tcm_dpram_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(2), .READ_MODE(1), .CLEAR_ON_RESET(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .init_i(init), .ready_o(ready_b),
        .addr0_i(a0), .data0_i(d0), .wr0_i(w0), .rd0_i(r0), .data0_o(b_d0), .valid0_o(b_v0),
        .addr1_i(a1), .data1_i(d1), .wr1_i(w1), .rd1_i(r1), .data1_o(b_d1), .valid1_o(b_v1),
        .collision_o(coll_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_ready;
    int            m_clr;
    int            edge_n;
    logic          pend_v [4][4];
    logic [DW-1:0] pend_d [4][4];
    logic          exp_v [4];
    logic [DW-1:0] exp_d [4];
    logic          exp_coll;

    function automatic logic [DW-1:0] lane_merge(logic [DW-1:0] base, logic [DW-1:0] nd, logic [NB-1:0] en);
        logic [DW-1:0] r;
        r = base;
        for (int b = 0; b < NB; b++) if (en[b]) r[b*8 +: 8] = nd[b*8 +: 8];
        return r;
    endfunction

    task automatic idle();
        init = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; w0 = '0; w1 = '0; r0 = 0; r1 = 0;
    endtask

    task automatic rand_traffic();
        a0 = AW'($urandom);
        a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom);
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        w0 = $urandom_range(0, 1) ? NB'($urandom) : '0;
        w1 = $urandom_range(0, 1) ? NB'($urandom) : '0;
        r0 = 1'($urandom_range(0, 1));
        r1 = 1'($urandom_range(0, 1));
    endtask

    // Advance one clock: update the model from the current inputs, then sample after the edge
    task automatic tick();
        logic [DW-1:0] old0, old1;
        int s1, s2;
        s1 = edge_n % 4;
        s2 = (edge_n + 1) % 4;
        exp_coll = 1'b0;
        if (rst) begin
            m_ready = 1'b0;
            m_clr   = 0;
            for (int k = 0; k < 4; k++) begin
                for (int s = 0; s < 4; s++) pend_v[k][s] = 1'b0;
                exp_d[k] = '0;
            end
        end else if (!m_ready) begin
            m_mem[m_clr] = '0;
            m_clr++;
            if (m_clr == DEPTH) m_ready = 1'b1;
        end else begin
            old0 = m_mem[a0];
            old1 = m_mem[a1];
            if (r0) begin
                pend_v[0][s1] = 1'b1; pend_d[0][s1] = old0;
                pend_v[2][s2] = 1'b1; pend_d[2][s2] = lane_merge(old0, d0, w0);
            end
            if (r1) begin
                pend_v[1][s1] = 1'b1; pend_d[1][s1] = old1;
                pend_v[3][s2] = 1'b1; pend_d[3][s2] = lane_merge(old1, d1, w1);
            end
            m_mem[a1] = lane_merge(m_mem[a1], d1, w1);
            m_mem[a0] = lane_merge(m_mem[a0], d0, w0);
            exp_coll = (a0 == a1) && ((w0 & w1) != '0);
            if (init) begin
                m_ready = 1'b0;
                m_clr   = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = pend_v[k][s1];
            if (exp_v[k]) exp_d[k] = pend_d[k][s1];
            pend_v[k][s1] = 1'b0;
        end
        edge_n++;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (vout[k] !== 1'b0 || dout[k] !== '0) $display("FAIL reset_out[%0d]: got v=%b d=%h exp v=0 d=0", k, vout[k], dout[k]); else n_pass++;
        end
        n_checks++; if (coll_a !== 1'b0 || coll_b !== 1'b0) $display("FAIL reset_coll: got %b/%b exp 0/0", coll_a, coll_b); else n_pass++;
        n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL reset_ready0 cyc 0: got %b/%b exp 0/0", ready_a, ready_b); else n_pass++;
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL reset_ready0 cyc %0d: got %b/%b exp 0/0", i, ready_a, ready_b); else n_pass++;
        end
        tick();
        n_checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) $display("FAIL reset_ready1: got %b/%b exp 1/1", ready_a, ready_b); else n_pass++;
        for (int j = 0; j <= DEPTH; j++) begin
            idle();
            if (j < DEPTH) begin
                a0 = AW'(j); a1 = AW'(DEPTH - 1 - j); r0 = 1; r1 = 1;
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                logic ev;
                ev = (k < 2) ? (j < DEPTH) : (j >= 1);
                n_checks++; if (vout[k] !== ev || dout[k] !== '0) $display("FAIL reset_readback[%0d] j=%0d: got v=%b d=%h exp v=%b d=0", k, j, vout[k], dout[k], ev); else n_pass++;
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] word;
        word = 64'h1122334455667788;
        idle(); a0 = 4'd5; d0 = word; w0 = 8'hFF; tick();
        idle(); a0 = 4'd5; r0 = 1; tick();
        idle();
        n_checks++; if (vout[0] !== 1'b1 || dout[0] !== word) $display("FAIL wr_rd_lat1: got v=%b d=%h exp v=1 d=%h", vout[0], dout[0], word); else n_pass++;
        n_checks++; if (vout[2] !== 1'b0) $display("FAIL wr_rd_lat2_early: got v=%b exp 0", vout[2]); else n_pass++;
        tick();
        n_checks++; if (vout[0] !== 1'b0 || dout[0] !== word) $display("FAIL wr_rd_lat1_hold: got v=%b d=%h exp v=0 d=%h", vout[0], dout[0], word); else n_pass++;
        n_checks++; if (vout[2] !== 1'b1 || dout[2] !== word) $display("FAIL wr_rd_lat2: got v=%b d=%h exp v=1 d=%h", vout[2], dout[2], word); else n_pass++;
        tick();
        n_checks++; if (vout[2] !== 1'b0 || dout[2] !== word) $display("FAIL wr_rd_lat2_hold: got v=%b d=%h exp v=0 d=%h", vout[2], dout[2], word); else n_pass++;
    endtask

    task automatic test_collision();
        logic [DW-1:0] word;
        word = 64'h0000BBBBAAAAAAAA;
        idle();
        a0 = 4'd3; a1 = 4'd3; d0 = {16{4'hA}}; d1 = {16{4'hB}}; w0 = 8'h0F; w1 = 8'h3C;
        tick();
        idle();
        n_checks++; if (coll_a !== 1'b1 || coll_b !== 1'b1) $display("FAIL coll_pulse: got %b/%b exp 1/1", coll_a, coll_b); else n_pass++;
        a1 = 4'd3; r1 = 1; tick(); idle();
        n_checks++; if (coll_a !== 1'b0 || coll_b !== 1'b0) $display("FAIL coll_clear: got %b/%b exp 0/0", coll_a, coll_b); else n_pass++;
        n_checks++; if (vout[1] !== 1'b1 || dout[1] !== word) $display("FAIL coll_word_a: got v=%b d=%h exp v=1 d=%h", vout[1], dout[1], word); else n_pass++;
        tick();
        n_checks++; if (vout[3] !== 1'b1 || dout[3] !== word) $display("FAIL coll_word_b: got v=%b d=%h exp v=1 d=%h", vout[3], dout[3], word); else n_pass++;
        // different addresses, same lanes: independent, no collision
        a0 = 4'd9; a1 = 4'd10; d0 = 64'h5; d1 = 64'h6; w0 = 8'hFF; w1 = 8'hFF; tick(); idle();
        n_checks++; if (coll_a !== 1'b0 || coll_b !== 1'b0) $display("FAIL coll_diff_addr: got %b/%b exp 0/0", coll_a, coll_b); else n_pass++;
        a0 = 4'd10; a1 = 4'd9; r0 = 1; r1 = 1; tick(); idle();
        n_checks++; if (dout[0] !== 64'h6 || dout[1] !== 64'h5) $display("FAIL indep_rd: got %h/%h exp 6/5", dout[0], dout[1]); else n_pass++;
        tick();
    endtask

    task automatic test_same_port();
        idle(); a0 = 4'd7; d0 = 64'h1; w0 = 8'hFF; tick();
        idle(); a1 = 4'd7; d1 = 64'h2; w1 = 8'hFF; r1 = 1; a0 = 4'd7; r0 = 1; tick();
        idle();
        n_checks++; if (dout[1] !== 64'h1) $display("FAIL same_port_read_first: got %h exp 1", dout[1]); else n_pass++;
        n_checks++; if (dout[0] !== 64'h1) $display("FAIL cross_port_a: got %h exp 1", dout[0]); else n_pass++;
        tick();
        n_checks++; if (vout[3] !== 1'b1 || dout[3] !== 64'h2) $display("FAIL same_port_write_first: got v=%b d=%h exp v=1 d=2", vout[3], dout[3]); else n_pass++;
        n_checks++; if (dout[2] !== 64'h1) $display("FAIL cross_port_b: got %h exp 1", dout[2]); else n_pass++;
    endtask

    task automatic test_clear_restart();
        idle(); init = 1; tick(); idle();
        n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL init_ready: got %b/%b exp 0/0", ready_a, ready_b); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            rand_traffic(); init = 1; tick();
            n_checks++; if (ready_a !== 1'b0 || coll_a !== 1'b0 || coll_b !== 1'b0) $display("FAIL clr_phase1 cyc %0d: got rdy=%b coll=%b/%b exp 0", i, ready_a, coll_a, coll_b); else n_pass++;
        end
        idle(); rst = 1; rand_traffic(); tick(); rst = 0;
        for (int i = 1; i < DEPTH; i++) begin
            rand_traffic(); tick();
            n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL clr_restart_ready cyc %0d: got %b/%b exp 0/0", i, ready_a, ready_b); else n_pass++;
            n_checks++; if (vout[0] | vout[1] | vout[2] | vout[3] | coll_a | coll_b) $display("FAIL clr_quiet cyc %0d: got v=%b%b%b%b coll=%b%b exp all 0", i, vout[0], vout[1], vout[2], vout[3], coll_a, coll_b); else n_pass++;
        end
        idle(); tick();
        n_checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) $display("FAIL clr_restart_done: got %b/%b exp 1/1", ready_a, ready_b); else n_pass++;
        for (int j = 0; j <= DEPTH; j++) begin
            idle();
            if (j < DEPTH) begin
                a0 = AW'(j); a1 = AW'(DEPTH - 1 - j); r0 = 1; r1 = 1;
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                logic ev;
                ev = (k < 2) ? (j < DEPTH) : (j >= 1);
                n_checks++; if (vout[k] !== ev || dout[k] !== '0) $display("FAIL clr_readback[%0d] j=%0d: got v=%b d=%h exp v=%b d=0", k, j, vout[k], dout[k], ev); else n_pass++;
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            rand_traffic();
            init = ($urandom_range(0, 299) == 0);
            rst  = ($urandom_range(0, 999) == 0);
            tick();
            rst = 0;
            n_checks++; if (ready_a !== m_ready || ready_b !== m_ready) $display("FAIL rand_ready cyc %0d: got %b/%b exp %b", i, ready_a, ready_b, m_ready); else n_pass++;
            n_checks++; if (coll_a !== exp_coll || coll_b !== exp_coll) $display("FAIL rand_coll cyc %0d: got %b/%b exp %b", i, coll_a, coll_b, exp_coll); else n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (vout[k] !== exp_v[k]) $display("FAIL rand_valid[%0d] cyc %0d: got %b exp %b", k, i, vout[k], exp_v[k]); else n_pass++;
                n_checks++; if (dout[k] !== exp_d[k]) $display("FAIL rand_data[%0d] cyc %0d: got %h exp %h", k, i, dout[k], exp_d[k]); else n_pass++;
            end
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        m_ready  = 1'b0;
        m_clr    = 0;
        edge_n   = 0;
        exp_coll = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) begin
                pend_v[k][s] = 1'b0;
                pend_d[k][s] = '0;
            end
            exp_v[k] = 1'b0;
            exp_d[k] = '0;
        end
        test_reset();
        test_write_read();
        test_collision();
        test_same_port();
        test_clear_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
